// File: rtl/credit_bp_tx_pkg.sv
// Shared defaults and credit sizing for the credit-based link transmitter.
package credit_bp_tx_pkg;

  localparam int unsigned DEFAULT_VC_W          = 32'd2;
  localparam int unsigned DEFAULT_D_W           = 32'd32;
  localparam int unsigned DEFAULT_X_W           = 32'd4;
  localparam int unsigned DEFAULT_Y_W           = 32'd4;
  localparam int unsigned DEFAULT_VC_FIFO_DEPTH = 32'd32;

  // Bits needed to hold DEPTH-1 credits; never narrower than one bit.
  function automatic int unsigned credit_width(input int unsigned depth);
    if (depth <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  localparam int unsigned DEFAULT_CREDIT_W = credit_width(DEFAULT_VC_FIFO_DEPTH);

  typedef logic [DEFAULT_CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/noc_if.sv
// Point-to-point NoC link: one flit per cycle tagged by a one-hot VC pulse,
// with per-VC credit returns travelling the other way.
interface noc_if #(
  parameter int unsigned VC_W = 32'd2,
  parameter int unsigned D_W  = 32'd32,
  parameter int unsigned A_W  = 32'd8
);

  typedef struct packed {
    logic [A_W-1:0] addr;
  } routeinfo_t;

  typedef struct packed {
    logic [D_W-1:0] data;
  } payload_t;

  typedef struct packed {
    routeinfo_t routeinfo;
    payload_t   payload;
  } packet_t;

  packet_t         packet;
  logic [VC_W-1:0] vc_target;
  logic [VC_W-1:0] vc_credit_gnt;

  modport transmitter (output packet, output vc_target, input vc_credit_gnt);
  modport receiver    (input packet, input vc_target, output vc_credit_gnt);

endinterface

// File: rtl/credit_bp_tx_chk.sv
// Simulation-only protocol checks for the credit transmitter.
module credit_bp_tx_chk #(
  parameter int unsigned VC_W = 32'd2,
  parameter int unsigned W    = 32'd5,
  parameter int unsigned MAX  = 32'd31
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic [VC_W-1:0]         i_v,
  input logic [VC_W-1:0]         o_b,
  input logic [VC_W-1:0]         vc_target,
  input logic [VC_W-1:0]         vc_credit_gnt,
  input logic [VC_W-1:0][W-1:0]  credit
);

  a_onehot_v: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(i_v))
    else $error("credit_bp_tx: multi-hot i_v %b", i_v);

  a_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({o_b, vc_target}))
    else $error("credit_bp_tx: unknown value on o_b/vc_target");

  for (genvar g = 0; g < VC_W; g++) begin : g_vc_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(vc_credit_gnt[g] && (credit[g] == W'(MAX))))
      else $error("credit_bp_tx: credit grant on full VC %0d", g);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      ((credit[g] == '0) && !vc_credit_gnt[g]) |=> (credit[g] == '0))
      else $error("credit_bp_tx: credit underflow on VC %0d", g);
  end

endmodule

// File: rtl/credit_counter.sv
// Per-VC credit counter: decrements on an accepted flit, increments on a
// returned credit, and exposes a registered "empty" flag for backpressure.
module credit_counter #(
  parameter int unsigned MAX = 32'd31,
  parameter int unsigned W   = 32'd5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_dec,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE_C = W'(1'b1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         zero_q;
  logic         zero_d;

  // Next count: accept and grant together cancel out.
  always_comb begin
    count_d = count_q;
    if (i_dec && !i_inc) begin
      count_d = count_q - ONE_C;
    end else if (i_inc && !i_dec) begin
      count_d = count_q + ONE_C;
    end else begin
      count_d = count_q;
    end
    zero_d = (count_d == '0);
  end

  // Count and empty flag registers; reset fills the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= MAX_C;
      zero_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign o_count = count_q;
  assign o_zero  = zero_q;

endmodule

// File: rtl/credit_bp_tx.sv
// Transmitter half of the credit-based backpressure link: accepts one flit
// per cycle on a one-hot VC, tracks receiver space per VC, and drives the
// flit onto the link one cycle later.
module credit_bp_tx
  import credit_bp_tx_pkg::*;
#(
  parameter int unsigned VC_W  = DEFAULT_VC_W,
  parameter int unsigned D_W   = DEFAULT_D_W,
  parameter int unsigned X_W   = DEFAULT_X_W,
  parameter int unsigned Y_W   = DEFAULT_Y_W,
  parameter int unsigned A_W   = X_W + Y_W,
  parameter int unsigned DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [VC_W-1:0] i_v,
  input  logic [X_W-1:0]  i_x,
  input  logic [Y_W-1:0]  i_y,
  input  logic [D_W-1:0]  i_d,
  output logic [VC_W-1:0] o_b,
  noc_if.transmitter      to_rx
);

  localparam int unsigned CREDIT_W = credit_width(DEPTH);

  logic [VC_W-1:0]               acc_s;
  logic [VC_W-1:0]               zero_s;
  logic [VC_W-1:0][CREDIT_W-1:0] credit_s;

  logic [VC_W-1:0] tgt_q;
  logic [VC_W-1:0] tgt_d;
  logic [A_W-1:0]  addr_q;
  logic [A_W-1:0]  addr_d;
  logic [D_W-1:0]  data_q;
  logic [D_W-1:0]  data_d;

  // Backpressure comes only from registered counter state.
  assign o_b = zero_s;

  // Accept the lowest-index offered VC that has credit; others wait.
  always_comb begin
    logic found;
    acc_s = '0;
    found = 1'b0;
    for (int i = 0; i < VC_W; i++) begin
      if (!found && i_v[i] && !zero_s[i]) begin
        acc_s[i] = 1'b1;
        found    = 1'b1;
      end else begin
        acc_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < VC_W; g++) begin : g_vc
    credit_counter #(
      .MAX (DEPTH - 32'd1),
      .W   (CREDIT_W)
    ) u_credit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_dec   (acc_s[g]),
      .i_inc   (to_rx.vc_credit_gnt[g]),
      .o_count (credit_s[g]),
      .o_zero  (zero_s[g])
    );
  end

  // Output stage next state: pulse per accepted flit, hold packet otherwise.
  always_comb begin
    tgt_d  = acc_s;
    addr_d = addr_q;
    data_d = data_q;
    if (|acc_s) begin
      addr_d = {i_x, i_y};
      data_d = i_d;
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  // Output stage registers; reset drops any in-flight pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      tgt_q  <= tgt_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign to_rx.vc_target = tgt_q;
  assign to_rx.packet    = {addr_q, data_q};

  credit_bp_tx_chk #(
    .VC_W (VC_W),
    .W    (CREDIT_W),
    .MAX  (DEPTH - 32'd1)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_v           (i_v),
    .o_b           (o_b),
    .vc_target     (tgt_q),
    .vc_credit_gnt (to_rx.vc_credit_gnt),
    .credit        (credit_s)
  );

endmodule
